enc424j600_reg_access: RTL and testbench

ENC424J600_REG_ACCESS -- requirements
Module: enc424j600_reg_access

---
 rtl/enc424j600_pkg.sv | 35 +++
 rtl/enc424j600_reg_access.sv | 161 ++++++++++++++++
 tb/tb_enc424j600_reg_access.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enc424j600_pkg.sv
// Shared opcodes, SFR bound and FSM encoding for
// the ENC424J600 unbanked register access block.
package enc424j600_pkg;

  localparam logic [7:0] OPC_RCRU = 8'h20;
  localparam logic [7:0] OPC_WCRU = 8'h22;
  localparam logic [7:0] OPC_BFSU = 8'h24;
  localparam logic [7:0] OPC_BFCU = 8'h26;

  localparam logic [7:0]  SFR_LIMIT = 8'hA0;
  localparam logic [1:0]  OP_RD     = 2'd0;
  localparam logic [10:0] NBYTES    = 11'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DATA,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  function automatic logic [7:0] opcode_of(
    input logic [1:0] op
  );
    logic [7:0] opc;
    unique case (op)
      2'd0:    opc = OPC_RCRU;
      2'd1:    opc = OPC_WCRU;
      2'd2:    opc = OPC_BFSU;
      default: opc = OPC_BFCU;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/enc424j600_reg_access.sv
// Unbanked SFR read/write/bit-op sequencer for an SPI master.
// ENC424J600_REG_TIMEOUT_EN adds a txn_done watchdog.
import enc424j600_pkg::*;

module enc424j600_reg_access #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] opbyte,
  output logic        opbyte_valid,
  output logic [10:0] nbyte_num,
  output logic [7:0]  wrdat_byte,
  output logic        wrdat_valid,
  input  logic        wrdat_ready,
  input  logic [7:0]  rddat_byte,
  input  logic        rddat_valid,
  input  logic        txn_done
);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;

  logic is_rd;
  logic xfer;
  logic last;

  assign is_rd = (op_q == OP_RD);

`ifdef ENC424J600_REG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy;

  assign busy = (state_q == ST_ISSUE) ||
                (state_q == ST_DATA) ||
                (state_q == ST_WAIT_DONE);
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (req_addr >= SFR_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA: begin
        xfer = is_rd ? rddat_valid : wrdat_ready;
        last = xfer && cnt_q[0];
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          if (is_rd && cnt_q[0])
            rdata_d[15:8] = rddat_byte;
          else if (is_rd)
            rdata_d[7:0] = rddat_byte;
        end
        // early done means the master dropped bytes
        if (txn_done) begin
          state_d = ST_RESP;
          err_d   = !last;
        end else if (last) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (txn_done) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef ENC424J600_REG_TIMEOUT_EN
    tmo_d = busy ? tmo_q + 1'b1 : '0;
    if (busy && tmo_q == TMO_LAST &&
        state_d != ST_RESP) begin
      state_d = ST_RESP;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ENC424J600_REG_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign req_ready    = rst_n && (state_q == ST_IDLE);
  assign opbyte_valid = (state_q == ST_ISSUE);
  assign opbyte       = opbyte_valid ?
                        {addr_q, opcode_of(op_q)} : '0;
  assign nbyte_num    = opbyte_valid ? NBYTES : '0;
  assign wrdat_valid  = (state_q == ST_DATA) && !is_rd;
  assign wrdat_byte   = !wrdat_valid ? '0 :
                        cnt_q[0] ? wdata_q[15:8] :
                                   wdata_q[7:0];
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rsp_valid ? rdata_q : '0;
  assign rsp_err      = rsp_valid && err_q;

endmodule

// File: tb/tb_enc424j600_reg_access.sv
// Scoreboard bench: stimulus queues expectations,
// negedge monitor pops and compares DUT output.
module tb_enc424j600_reg_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] opbyte;
  logic        opbyte_valid;
  logic [10:0] nbyte_num;
  logic [7:0]  wrdat_byte;
  logic        wrdat_valid;
  logic        wrdat_ready = 1'b0;
  logic [7:0]  rddat_byte = '0;
  logic        rddat_valid = 1'b0;
  logic        txn_done = 1'b0;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [26:0] op_q[$];
  logic [7:0]  wb_q[$];

  int n_vec = 0;
  int n_bad = 0;

  enc424j600_reg_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .opbyte       (opbyte),
    .opbyte_valid (opbyte_valid),
    .nbyte_num    (nbyte_num),
    .wrdat_byte   (wrdat_byte),
    .wrdat_valid  (wrdat_valid),
    .wrdat_ready  (wrdat_ready),
    .rddat_byte   (rddat_byte),
    .rddat_valid  (rddat_valid),
    .txn_done     (txn_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (opbyte_valid) begin
        if (op_q.size() == 0) begin
          chk("opbyte_unexpected", 1, 0);
        end else begin
          logic [26:0] eo;
          eo = op_q.pop_front();
          chk("opbyte", 32'(opbyte), 32'(eo[26:11]));
          chk("nbyte_num", 32'(nbyte_num), 32'(eo[10:0]));
        end
      end
      if (wrdat_valid && wrdat_ready) begin
        if (wb_q.size() == 0) begin
          chk("wrdat_unexpected", 1, 0);
        end else begin
          logic [7:0] eb;
          eb = wb_q.pop_front();
          chk("wrdat_byte", 32'(wrdat_byte), 32'(eb));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(
    input logic [1:0]  op,
    input logic [7:0]  a,
    input logic [15:0] d
  );
    int k = 0;
    while (!req_ready && k < 50) begin
      step();
      k++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_op(
    input logic [7:0] a,
    input logic [7:0] opc
  );
    op_q.push_back({a, opc, 11'd3});
  endtask

  task automatic push_rsp(
    input logic [15:0] rd,
    input logic        er
  );
    rsp_t r;
    r.rdata = rd;
    r.err   = er;
    rsp_q.push_back(r);
  endtask

  task automatic wr_bytes(
    input int          stall,
    input logic [15:0] d
  );
    for (int b = 0; b < 2; b++) begin
      logic [7:0] eb;
      eb = (b == 0) ? d[7:0] : d[15:8];
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("wr_hold_valid", 32'(wrdat_valid), 1);
        chk("wr_hold_byte", 32'(wrdat_byte), 32'(eb));
        step();
      end
      wrdat_ready = 1'b1;
      step();
      wrdat_ready = 1'b0;
    end
  endtask

  task automatic pulse_done();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
  endtask

  task automatic rd_bytes(input logic [15:0] d);
    rddat_valid = 1'b1;
    rddat_byte  = d[7:0];
    step();
    rddat_byte  = d[15:8];
    step();
    rddat_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_opbyte_valid", 32'(opbyte_valid), 0);
    chk("rst_opbyte", 32'(opbyte), 0);
    chk("rst_nbyte", 32'(nbyte_num), 0);
    chk("rst_wrdat_valid", 32'(wrdat_valid), 0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    step();

    // read 0x8D, stray byte in ISSUE, done with last byte
    push_op(8'h8D, 8'h20);
    push_rsp(16'h1234, 1'b0);
    do_req(2'd0, 8'h8D, 16'h0);
    rddat_valid = 1'b1;
    rddat_byte  = 8'hFF;
    step();
    rddat_byte  = 8'h34;
    step();
    rddat_byte  = 8'h12;
    txn_done    = 1'b1;
    step();
    rddat_valid = 1'b0;
    txn_done    = 1'b0;

    // read 0x10, extra byte in WAIT_DONE, late done
    push_op(8'h10, 8'h20);
    push_rsp(16'hABCD, 1'b0);
    do_req(2'd0, 8'h10, 16'h0);
    step();
    rd_bytes(16'hABCD);
    rddat_valid = 1'b1;
    rddat_byte  = 8'h77;
    step();
    rddat_valid = 1'b0;
    pulse_done();

    // WCRU 0x7E <- BEEF
    push_op(8'h7E, 8'h22);
    wb_q.push_back(8'hEF);
    wb_q.push_back(8'hBE);
    push_rsp(16'h0, 1'b0);
    do_req(2'd1, 8'h7E, 16'hBEEF);
    @(negedge clk);
    chk("wr_issue_novalid", 32'(wrdat_valid), 0);
    step();
    wr_bytes(0, 16'hBEEF);
    pulse_done();

    // BFCU 0x00 mask 0x0080, 10-cycle stalls
    push_op(8'h00, 8'h26);
    wb_q.push_back(8'h80);
    wb_q.push_back(8'h00);
    push_rsp(16'h0, 1'b0);
    do_req(2'd3, 8'h00, 16'h0080);
    step();
    wr_bytes(10, 16'h0080);
    pulse_done();

    // BFSU at highest legal address 0x9F
    push_op(8'h9F, 8'h24);
    wb_q.push_back(8'hA5);
    wb_q.push_back(8'h5A);
    push_rsp(16'h0, 1'b0);
    do_req(2'd2, 8'h9F, 16'h5AA5);
    step();
    wr_bytes(1, 16'h5AA5);
    pulse_done();

    // out-of-range addresses
    push_rsp(16'h0, 1'b1);
    do_req(2'd0, 8'hA0, 16'h0);
    @(negedge clk);
    chk("bad_rsp_fast", 32'(rsp_valid), 1);
    step();
    push_rsp(16'h0, 1'b1);
    do_req(2'd1, 8'hFF, 16'h1234);
    step();

    // txn_done before any byte
    push_op(8'h42, 8'h20);
    push_rsp(16'h0, 1'b1);
    do_req(2'd0, 8'h42, 16'h0);
    step();
    pulse_done();

    // reset while in DATA
    push_op(8'h7E, 8'h22);
    do_req(2'd1, 8'h7E, 16'h1111);
    step();
    chk("pre_rst_in_data", 32'(wrdat_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wrdat_valid", 32'(wrdat_valid), 0);
    chk("mid_rst_wrdat_byte", 32'(wrdat_byte), 0);
    chk("mid_rst_opbyte_valid", 32'(opbyte_valid), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(req_ready), 1);
    step();
    push_op(8'h8D, 8'h20);
    push_rsp(16'hC0DE, 1'b0);
    do_req(2'd0, 8'h8D, 16'h0);
    step();
    rd_bytes(16'hC0DE);
    pulse_done();

`ifdef ENC424J600_REG_TIMEOUT_EN
    begin
      int k;
      push_op(8'h33, 8'h20);
      push_rsp(16'h0, 1'b1);
      do_req(2'd0, 8'h33, 16'h0);
      k = 0;
      while (k < 40) begin
        @(negedge clk);
        if (rsp_valid) break;
        step();
        k++;
      end
      chk("timeout_cycle", 32'(k), 16);
      step();
    end
`else
    push_op(8'h33, 8'h20);
    push_rsp(16'h5678, 1'b0);
    do_req(2'd0, 8'h33, 16'h0);
    repeat (40) step();
    @(negedge clk);
    chk("no_tmo_ready", 32'(req_ready), 0);
    chk("no_tmo_rsp", 32'(rsp_valid), 0);
    step();
    rd_bytes(16'h5678);
    pulse_done();
`endif

    repeat (3) step();
    chk("rsp_q_drained", 32'(rsp_q.size()), 0);
    chk("op_q_drained", 32'(op_q.size()), 0);
    chk("wb_q_drained", 32'(wb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
